// File: rtl/multi_burst_accel_wrap.sv
// Host<->HLS-kernel wrapper: burst-load a scratchpad, run a two-port kernel on it, burst-write results back.
// States: IDLE wait | CHECK latch+bounds | READ host load | KRUN kernel owns BRAM | WFETCH/WRITE write-back | FIN done pulse
module multi_burst_accel_wrap #(
    parameter int DATA_WID  = 32,
    parameter int ADDR_WID  = 13,
    parameter int HADDR_WID = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [HADDR_WID-1:0] read_base,
    input  logic [HADDR_WID-1:0] write_base,
    input  logic [HADDR_WID-1:0] num_read,
    input  logic [HADDR_WID-1:0] num_write,
    input  logic [ADDR_WID-1:0]  wb_offset,
    input  logic [HADDR_WID-1:0] stride,
    input  logic                 read_ready,
    input  logic [DATA_WID-1:0]  read_data,
    input  logic                 write_ready,
    output logic                 read_enable,
    output logic                 finish_read,
    output logic [HADDR_WID-1:0] read_addr,
    output logic [HADDR_WID-1:0] read_size_output,
    output logic                 write_enable,
    output logic                 finish_write,
    output logic [HADDR_WID-1:0] write_addr,
    output logic [HADDR_WID-1:0] write_size,
    output logic [DATA_WID-1:0]  write_data,
    output logic                 done,
    output logic                 busy,
    output logic                 error,
    output logic [63:0]          cycles,
    output logic                 k_start,
    input  logic                 k_done,
    input  logic [ADDR_WID-1:0]  k_addr0,
    input  logic [ADDR_WID-1:0]  k_addr1,
    input  logic                 k_ce0,
    input  logic                 k_ce1,
    input  logic                 k_we0,
    input  logic                 k_we1,
    input  logic [DATA_WID-1:0]  k_d0,
    input  logic [DATA_WID-1:0]  k_d1,
    output logic [DATA_WID-1:0]  k_q0,
    output logic [DATA_WID-1:0]  k_q1
);
    localparam int DEPTH = 2 ** ADDR_WID;
    localparam logic [HADDR_WID-1:0] DEPTH_H = HADDR_WID'(DEPTH);
    localparam logic [HADDR_WID:0]   DEPTH_X = (HADDR_WID + 1)'(DEPTH);
    localparam logic [HADDR_WID-1:0] ONE_H   = HADDR_WID'(1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_KRUN, S_WFETCH, S_WRITE, S_FIN} state_t;

    state_t                state_q, state_d;
    logic [HADDR_WID-1:0]  read_base_q, read_base_d, write_base_q, write_base_d;
    logic [HADDR_WID-1:0]  num_read_q, num_read_d, num_write_q, num_write_d;
    logic [HADDR_WID-1:0]  stride_q, stride_d;
    logic [ADDR_WID-1:0]   wb_offset_q, wb_offset_d;
    logic [HADDR_WID-1:0]  rcnt_q, rcnt_d, wcnt_q, wcnt_d;
    logic [HADDR_WID-1:0]  read_addr_q, read_addr_d, write_addr_q, write_addr_d;
    logic [DATA_WID-1:0]   write_data_q, write_data_d;
    logic                  finish_read_q, finish_read_d, finish_write_q, finish_write_d;
    logic                  k_start_q, k_start_d, error_q, error_d;
    logic [63:0]           cycles_q, cycles_d;
    logic [DATA_WID-1:0]   k_q0_q, k_q0_d, k_q1_q, k_q1_d;
    logic [DATA_WID-1:0]   mem_q [DEPTH];
    logic [HADDR_WID:0]    wb_end;
    logic [ADDR_WID-1:0]   wb_idx;
    logic                  host_wr, k_wr0, k_wr1;

    // 65-bit sum so a huge num_write cannot wrap past the bound check
    assign wb_end  = (HADDR_WID + 1)'(wb_offset_q) + (HADDR_WID + 1)'(num_write_q);
    assign wb_idx  = wb_offset_q + wcnt_q[ADDR_WID-1:0];
    assign host_wr = (state_q == S_READ) && read_ready;
    assign k_wr0   = (state_q == S_KRUN) && k_ce0 && k_we0;
    assign k_wr1   = (state_q == S_KRUN) && k_ce1 && k_we1;

    always_comb begin
        state_d        = state_q;
        read_base_d    = read_base_q;
        write_base_d   = write_base_q;
        num_read_d     = num_read_q;
        num_write_d    = num_write_q;
        stride_d       = stride_q;
        wb_offset_d    = wb_offset_q;
        rcnt_d         = rcnt_q;
        wcnt_d         = wcnt_q;
        read_addr_d    = read_addr_q;
        write_addr_d   = write_addr_q;
        write_data_d   = write_data_q;
        finish_read_d  = 1'b0;
        finish_write_d = 1'b0;
        k_start_d      = 1'b0;
        error_d        = error_q;
        cycles_d       = cycles_q;
        k_q0_d         = k_q0_q;
        k_q1_d         = k_q1_q;
        if (state_q != S_IDLE && state_q != S_FIN) cycles_d = cycles_q + 64'd1;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    read_base_d  = read_base;
                    write_base_d = write_base;
                    num_read_d   = num_read;
                    num_write_d  = num_write;
                    stride_d     = stride;
                    wb_offset_d  = wb_offset;
                    error_d      = 1'b0;
                    cycles_d     = 64'd1;
                    state_d      = S_CHECK;
                end
            end
            S_CHECK: begin
                rcnt_d       = '0;
                wcnt_d       = '0;
                write_addr_d = write_base_q;
                if (num_read_q > DEPTH_H || wb_end > DEPTH_X) begin
                    error_d = 1'b1;
                    state_d = S_FIN;
                end else if (num_read_q == '0) begin
                    k_start_d = 1'b1;
                    state_d   = S_KRUN;
                end else begin
                    read_addr_d = read_base_q;
                    state_d     = S_READ;
                end
            end
            S_READ: begin
                if (read_ready) begin
                    read_addr_d = read_addr_q + stride_q;
                    rcnt_d      = rcnt_q + ONE_H;
                    if (rcnt_q + ONE_H == num_read_q) begin
                        k_start_d = 1'b1;
                        state_d   = S_KRUN;
                    end else begin
                        finish_read_d = 1'b1;
                    end
                end
            end
            S_KRUN: begin
                if (k_ce0 && !k_we0) k_q0_d = mem_q[k_addr0];
                if (k_ce1 && !k_we1) k_q1_d = mem_q[k_addr1];
                if (k_done) state_d = (num_write_q == '0) ? S_FIN : S_WFETCH;
            end
            S_WFETCH: begin
                write_data_d = mem_q[wb_idx];
                state_d      = S_WRITE;
            end
            S_WRITE: begin
                if (write_ready) begin
                    write_addr_d = write_addr_q + stride_q;
                    wcnt_d       = wcnt_q + ONE_H;
                    if (wcnt_q + ONE_H == num_write_q) begin
                        state_d = S_FIN;
                    end else begin
                        finish_write_d = 1'b1;
                        state_d        = S_WFETCH;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            read_base_q    <= '0;
            write_base_q   <= '0;
            num_read_q     <= '0;
            num_write_q    <= '0;
            stride_q       <= '0;
            wb_offset_q    <= '0;
            rcnt_q         <= '0;
            wcnt_q         <= '0;
            read_addr_q    <= '0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            finish_read_q  <= 1'b0;
            finish_write_q <= 1'b0;
            k_start_q      <= 1'b0;
            error_q        <= 1'b0;
            cycles_q       <= '0;
            k_q0_q         <= '0;
            k_q1_q         <= '0;
        end else begin
            state_q        <= state_d;
            read_base_q    <= read_base_d;
            write_base_q   <= write_base_d;
            num_read_q     <= num_read_d;
            num_write_q    <= num_write_d;
            stride_q       <= stride_d;
            wb_offset_q    <= wb_offset_d;
            rcnt_q         <= rcnt_d;
            wcnt_q         <= wcnt_d;
            read_addr_q    <= read_addr_d;
            write_addr_q   <= write_addr_d;
            write_data_q   <= write_data_d;
            finish_read_q  <= finish_read_d;
            finish_write_q <= finish_write_d;
            k_start_q      <= k_start_d;
            error_q        <= error_d;
            cycles_q       <= cycles_d;
            k_q0_q         <= k_q0_d;
            k_q1_q         <= k_q1_d;
        end
    end

    // Port 1 is written last so it wins a same-address collision with port 0
    always_ff @(posedge clk) begin
        if (host_wr) mem_q[rcnt_q[ADDR_WID-1:0]] <= read_data;
        if (k_wr0)   mem_q[k_addr0] <= k_d0;
        if (k_wr1)   mem_q[k_addr1] <= k_d1;
    end

    assign read_enable      = (state_q == S_READ);
    assign write_enable     = (state_q == S_WRITE);
    assign done             = (state_q == S_FIN);
    assign busy             = (state_q != S_IDLE) && (state_q != S_FIN);
    assign finish_read      = finish_read_q;
    assign finish_write     = finish_write_q;
    assign read_addr        = read_addr_q;
    assign write_addr       = write_addr_q;
    assign read_size_output = stride_q;
    assign write_size       = stride_q;
    assign write_data       = write_data_q;
    assign error            = error_q;
    assign cycles           = cycles_q;
    assign k_start          = k_start_q;
    assign k_q0             = k_q0_q;
    assign k_q1             = k_q1_q;
endmodule
